truth_table_lut: RTL and testbench



---
 rtl/truth_table_lut_pkg.sv | 21 ++
 rtl/truth_table_lut_if.sv | 34 +++
 rtl/truth_table_lut_tt_shift_loader.sv | 103 ++++++++++
 rtl/truth_table_lut.sv | 97 +++++++++
 tb/tb_truth_table_lut.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/truth_table_lut_pkg.sv
`default_nettype none
// ============================================================================
// Module   : truth_table_pkg
// Brief    : Shared types, constants and helpers for the truth-table LUT.
// Revision : 1.0  initial release
// ============================================================================
package truth_table_pkg;

    localparam int MAX_N_IN = 6;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        LOAD = 1'b1
    } cfg_state_t;

    function automatic int tt_width(input int n);
        return 1 << n;
    endfunction

endpackage : truth_table_pkg
`default_nettype wire

// File: rtl/truth_table_lut_if.sv
`default_nettype none
// ============================================================================
// Module   : truth_table_lut_if
// Brief    : Evaluation handshake and serial configuration bundle.
// Revision : 1.0  initial release
// ============================================================================
interface truth_table_lut_if #(
    parameter int N_IN = 3
) ();

    logic            in_valid;
    logic            in_ready;
    logic [N_IN-1:0] in_vec;
    logic            out_valid;
    logic            out_ready;
    logic            out_bit;
    logic            cfg_start;
    logic            cfg_valid;
    logic            cfg_bit;
    logic            cfg_busy;
    logic            cfg_done;

    modport master (
        output in_valid, in_vec, out_ready, cfg_start, cfg_valid, cfg_bit,
        input  in_ready, out_valid, out_bit, cfg_busy, cfg_done
    );

    modport slave (
        input  in_valid, in_vec, out_ready, cfg_start, cfg_valid, cfg_bit,
        output in_ready, out_valid, out_bit, cfg_busy, cfg_done
    );

endinterface : truth_table_lut_if
`default_nettype wire

// File: rtl/truth_table_lut_tt_shift_loader.sv
`default_nettype none
// ============================================================================
// Module   : tt_shift_loader
// Brief    : Serial truth-table loader (IDLE/LOAD FSM, counter, shadow word).
//            TT_READBACK_EN adds the o_err aborted-load pulse.
// Revision : 1.0  initial release
// ============================================================================
module tt_shift_loader
    import truth_table_pkg::*;
#(
    parameter int N_IN = 3
) (
    input  wire logic                        clk,
    input  wire logic                        reset,
    input  wire logic                        i_cfg_start,
    input  wire logic                        i_cfg_valid,
    input  wire logic                        i_cfg_bit,
    output logic                             o_busy,
    output logic                             o_done,
    output logic                             o_commit,
    output logic [tt_width(N_IN)-1:0]        o_shadow
`ifdef TT_READBACK_EN
   ,output logic                             o_err
`endif
);

    localparam int                c_tt_w = tt_width(N_IN);
    localparam logic [N_IN:0]     c_last = (N_IN+1)'(c_tt_w - 1);

    cfg_state_t          r_state, w_state_nxt;
    logic [N_IN:0]       r_count, w_count_nxt;
    logic [c_tt_w-1:0]   r_shadow, w_shadow_nxt;
    logic                r_done;
    logic                w_commit;
    logic                w_abort;
`ifdef TT_READBACK_EN
    logic                r_err;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_count  <= '0;
            r_shadow <= '0;
            r_done   <= 1'b0;
`ifdef TT_READBACK_EN
            r_err    <= 1'b0;
`endif
        end else begin
            r_state  <= w_state_nxt;
            r_count  <= w_count_nxt;
            r_shadow <= w_shadow_nxt;
            r_done   <= w_commit;
`ifdef TT_READBACK_EN
            r_err    <= w_abort;
`endif
        end
    end

    // A start pulse always wins over a coincident data bit, in either state.
    always_comb begin
        w_state_nxt  = r_state;
        w_count_nxt  = r_count;
        w_shadow_nxt = r_shadow;
        w_commit     = 1'b0;
        w_abort      = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_cfg_start) begin
                    w_state_nxt  = LOAD;
                    w_count_nxt  = '0;
                    w_shadow_nxt = '0;
                end
            end
            LOAD: begin
                if (i_cfg_start) begin
                    w_abort      = 1'b1;
                    w_count_nxt  = '0;
                    w_shadow_nxt = '0;
                end else if (i_cfg_valid) begin
                    w_shadow_nxt = {r_shadow[c_tt_w-2:0], i_cfg_bit};
                    w_count_nxt  = r_count + 1'b1;
                    if (r_count == c_last) begin
                        w_commit    = 1'b1;
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // The shadow handed over is the completed word including the final bit.
    assign o_busy   = (r_state == LOAD);
    assign o_done   = r_done;
    assign o_commit = w_commit;
    assign o_shadow = w_shadow_nxt;
`ifdef TT_READBACK_EN
    assign o_err    = r_err;
`endif

endmodule : tt_shift_loader
`default_nettype wire

// File: rtl/truth_table_lut.sv
`default_nettype none
// ============================================================================
// Module   : truth_table_lut
// Brief    : Reprogrammable N-input Boolean evaluator with registered output.
//            TT_READBACK_EN adds tt_active_o and cfg_err ports.
// Revision : 1.0  initial release
// ============================================================================
module truth_table_lut
    import truth_table_pkg::*;
#(
    parameter int                         N_IN    = 3,
    parameter logic [tt_width(N_IN)-1:0]  INIT_TT = 8'hEC
) (
    input  wire logic                     clk,
    input  wire logic                     reset,
    truth_table_lut_if.slave              tt_bus
`ifdef TT_READBACK_EN
   ,output logic [tt_width(N_IN)-1:0]     tt_active_o
   ,output logic                          cfg_err
`endif
);

    localparam int c_tt_w = tt_width(N_IN);

    generate
        if (N_IN < 1 || N_IN > MAX_N_IN) begin : g_bad_n_in
            $error("truth_table_lut: N_IN out of range");
        end
    endgenerate

    logic [c_tt_w-1:0] r_tt_active;
    logic [c_tt_w-1:0] w_tt_rev;
    logic [c_tt_w-1:0] w_shadow;
    logic              w_commit;
    logic              r_out_valid;
    logic              r_out_bit;
    logic              w_in_ready;
    logic              w_accept;
`ifdef TT_READBACK_EN
    logic              w_err;
`endif

    tt_shift_loader #(
        .N_IN        (N_IN)
    ) u_loader (
        .clk         (clk),
        .reset       (reset),
        .i_cfg_start (tt_bus.cfg_start),
        .i_cfg_valid (tt_bus.cfg_valid),
        .i_cfg_bit   (tt_bus.cfg_bit),
        .o_busy      (tt_bus.cfg_busy),
        .o_done      (tt_bus.cfg_done),
        .o_commit    (w_commit),
        .o_shadow    (w_shadow)
`ifdef TT_READBACK_EN
       ,.o_err       (w_err)
`endif
    );

    // Row 0 sits at the table MSB, so reverse once and index by in_vec.
    generate
        for (genvar gi = 0; gi < c_tt_w; gi++) begin : g_rev
            assign w_tt_rev[gi] = r_tt_active[c_tt_w-1-gi];
        end
    endgenerate

    assign w_in_ready = !r_out_valid || tt_bus.out_ready;
    assign w_accept   = tt_bus.in_valid && w_in_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tt_active <= INIT_TT;
            r_out_valid <= 1'b0;
            r_out_bit   <= 1'b0;
        end else begin
            if (w_commit) begin
                r_tt_active <= w_shadow;
            end
            if (w_accept) begin
                r_out_valid <= 1'b1;
                r_out_bit   <= w_tt_rev[tt_bus.in_vec];
            end else if (tt_bus.out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign tt_bus.in_ready  = w_in_ready;
    assign tt_bus.out_valid = r_out_valid;
    assign tt_bus.out_bit   = r_out_bit;
`ifdef TT_READBACK_EN
    assign tt_active_o      = r_tt_active;
    assign cfg_err          = w_err;
`endif

endmodule : truth_table_lut
`default_nettype wire

// File: tb/tb_truth_table_lut.sv
`default_nettype none
// ============================================================================
// Module   : tb_truth_table_lut
// Brief    : Directed self-checking bench for truth_table_lut (N_IN=3).
// Revision : 1.0  initial release
// ============================================================================
module tb_truth_table_lut;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;
    int   n_done;
    int   n_err;

    truth_table_lut_if #(.N_IN(3)) tt_bus ();

`ifdef TT_READBACK_EN
    logic [7:0] tt_active_o;
    logic       cfg_err;
`endif

    truth_table_lut #(
        .N_IN        (3),
        .INIT_TT     (8'hEC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .tt_bus      (tt_bus)
`ifdef TT_READBACK_EN
       ,.tt_active_o (tt_active_o)
       ,.cfg_err     (cfg_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        n_done = 0;
        n_err  = 0;
    end

    always @(negedge clk) begin
        if (tt_bus.cfg_done === 1'b1) n_done++;
`ifdef TT_READBACK_EN
        if (cfg_err === 1'b1) n_err++;
`endif
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One vector offered with out_ready high; result is checked one cycle later.
    task automatic eval_vec(input logic [2:0] vec, input logic exp_bit, input string tag);
        tt_bus.in_valid  = 1'b1;
        tt_bus.in_vec    = vec;
        tt_bus.out_ready = 1'b1;
        tick();
        tt_bus.in_valid  = 1'b0;
        check_val({tag, "_valid"}, 32'(tt_bus.out_valid), 32'd1);
        check_val({tag, "_bit"},   32'(tt_bus.out_bit),   32'(exp_bit));
    endtask

    task automatic cfg_shift(input logic [7:0] word, input int nbits);
        tt_bus.cfg_start = 1'b1;
        tick();
        tt_bus.cfg_start = 1'b0;
        check_val("cfg_busy_load", 32'(tt_bus.cfg_busy), 32'd1);
        for (int k = 0; k < nbits; k++) begin
            tt_bus.cfg_valid = 1'b1;
            tt_bus.cfg_bit   = word[7-k];
            tick();
        end
        tt_bus.cfg_valid = 1'b0;
    endtask

    initial begin
        logic [7:0] exp_ec;
        int         d0;
        int         e0;
        n_checks = 0;
        n_fail   = 0;
        exp_ec   = 8'b1110_1100;   // rows 0..7 read MSB-first

        reset            = 1'b1;
        tt_bus.in_valid  = 1'b0;
        tt_bus.in_vec    = '0;
        tt_bus.out_ready = 1'b1;
        tt_bus.cfg_start = 1'b0;
        tt_bus.cfg_valid = 1'b0;
        tt_bus.cfg_bit   = 1'b0;
        tick();
        tick();
        check_val("rst_in_ready",  32'(tt_bus.in_ready),  32'd1);
        check_val("rst_out_valid", 32'(tt_bus.out_valid), 32'd0);
        check_val("rst_out_bit",   32'(tt_bus.out_bit),   32'd0);
        check_val("rst_cfg_busy",  32'(tt_bus.cfg_busy),  32'd0);
        check_val("rst_cfg_done",  32'(tt_bus.cfg_done),  32'd0);
`ifdef TT_READBACK_EN
        check_val("rst_tt_active", 32'(tt_active_o), 32'hEC);
`endif
        reset = 1'b0;
        tick();

        // Back-to-back sweep of the reset table.
        for (int r = 0; r < 8; r++) begin
            eval_vec(3'(r), exp_ec[7-r], "sweep_ec");
        end
        tick();
        check_val("sweep_drain", 32'(tt_bus.out_valid), 32'd0);

        // Backpressure on row 3 (value 0), a row-0 vector waiting behind it.
        tt_bus.out_ready = 1'b0;
        tt_bus.in_valid  = 1'b1;
        tt_bus.in_vec    = 3'b011;
        tick();
        tt_bus.in_vec    = 3'b000;
        for (int c = 0; c < 3; c++) begin
            check_val("bp_valid",    32'(tt_bus.out_valid), 32'd1);
            check_val("bp_bit",      32'(tt_bus.out_bit),   32'd0);
            check_val("bp_in_ready", 32'(tt_bus.in_ready),  32'd0);
            tick();
        end
        tt_bus.out_ready = 1'b1;
        #1;
        check_val("bp_release_ready", 32'(tt_bus.in_ready), 32'd1);
        tick();
        tt_bus.in_valid = 1'b0;
        check_val("bp_next_bit", 32'(tt_bus.out_bit), 32'd1);
        tick();

        // Vector in the commit cycle of 0xFF sees the old table (row 3 = 0).
        cfg_shift(8'hFF, 7);
        tt_bus.cfg_valid = 1'b1;
        tt_bus.cfg_bit   = 1'b1;
        tt_bus.in_valid  = 1'b1;
        tt_bus.in_vec    = 3'b011;
        tick();
        tt_bus.cfg_valid = 1'b0;
        check_val("ff_commit_old", 32'(tt_bus.out_bit),  32'd0);
        check_val("ff_done",       32'(tt_bus.cfg_done), 32'd1);
        tick();
        tt_bus.in_valid  = 1'b0;
        check_val("ff_next_new", 32'(tt_bus.out_bit), 32'd1);
        tick();

        // 0x96 loaded row-0 first: rows 0..7 = 1,0,0,1,0,1,1,0.
        d0 = n_done;
        cfg_shift(8'h96, 8);
        check_val("x96_done", 32'(tt_bus.cfg_done), 32'd1);
        check_val("x96_busy", 32'(tt_bus.cfg_busy), 32'd0);
        tick();
        check_val("x96_done_clr", 32'(tt_bus.cfg_done), 32'd0);
        check_val("x96_done_once", 32'(n_done - d0), 32'd1);
        eval_vec(3'b111, 1'b0, "x96_r7");
        eval_vec(3'b110, 1'b1, "x96_r6");
        eval_vec(3'b000, 1'b1, "x96_r0");
        eval_vec(3'b011, 1'b1, "x96_r3");
        tick();

        // Reset mid-load with a pending result under backpressure.
        cfg_shift(8'hAA, 4);
        check_val("mid_busy", 32'(tt_bus.cfg_busy), 32'd1);
        tt_bus.out_ready = 1'b0;
        tt_bus.in_valid  = 1'b1;
        tt_bus.in_vec    = 3'b000;
        tick();
        tt_bus.in_valid  = 1'b0;
        check_val("mid_pending", 32'(tt_bus.out_valid), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tt_bus.out_ready = 1'b1;
        check_val("mid_rst_busy",  32'(tt_bus.cfg_busy),  32'd0);
        check_val("mid_rst_valid", 32'(tt_bus.out_valid), 32'd0);
        d0 = n_done;
        tt_bus.cfg_valid = 1'b1;
        tt_bus.cfg_bit   = 1'b1;
        for (int c = 0; c < 10; c++) tick();
        tt_bus.cfg_valid = 1'b0;
        check_val("mid_no_done",   32'(n_done - d0), 32'd0);
        check_val("idle_cfg_busy", 32'(tt_bus.cfg_busy), 32'd0);
        eval_vec(3'b000, 1'b1, "mid_init_r0");
        eval_vec(3'b011, 1'b0, "mid_init_r3");
        tick();

        // Aborted load followed by a full 0x01 load.
        d0 = n_done;
        e0 = n_err;
        cfg_shift(8'hAA, 5);
        cfg_shift(8'h01, 8);
        tick();
        tick();
        check_val("abort_done_once", 32'(n_done - d0), 32'd1);
`ifdef TT_READBACK_EN
        check_val("abort_err_once", 32'(n_err - e0), 32'd1);
        check_val("abort_tt_active", 32'(tt_active_o), 32'h01);
`endif
        for (int r = 0; r < 8; r++) begin
            eval_vec(3'(r), (r == 7), "x01_sweep");
        end
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_truth_table_lut
`default_nettype wire
